// File: rtl/sram_arbiter.sv
// Three-port arbiter and cycle sequencer for the external asynchronous SRAM.
// Port 0 has absolute priority; ports 1 and 2 share the remaining slots round-robin.
module sram_arbiter #(
  parameter int AW  = 19,
  parameter int ACC = 2   // strobe-active cycles per access, 1..15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic          we0,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] add0,
  input  logic [AW-1:0] add1,
  input  logic [AW-1:0] add2,
  input  logic [7:0]    wd0,
  input  logic [7:0]    wd1,
  input  logic [7:0]    wd2,
  output logic          ack0,
  output logic          ack1,
  output logic          ack2,
  output logic [7:0]    rdata,
  output logic          busy,
  output logic [AW-1:0] sram_add,
  input  logic [7:0]    sram_din,
  output logic [7:0]    sram_dout,
  output logic          sram_doe,
  output logic          sram_cs_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACC - 1);

  state_t        state, state_nx;
  logic [1:0]    port, port_nx;
  logic          lat_we, lat_we_nx;
  logic [AW-1:0] lat_add, lat_add_nx;
  logic [7:0]    lat_wd, lat_wd_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          last, last_nx;   // 1 = port 2 was served last
  logic          grant;

  always_comb begin
    state_nx   = state;
    port_nx    = port;
    lat_we_nx  = lat_we;
    lat_add_nx = lat_add;
    lat_wd_nx  = lat_wd;
    cnt_nx     = cnt;
    last_nx    = last;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (req0) begin
          grant      = 1'b1;
          port_nx    = 2'd0;
          lat_we_nx  = we0;
          lat_add_nx = add0;
          lat_wd_nx  = wd0;
        end else if (req1 && (!req2 || last)) begin
          grant      = 1'b1;
          port_nx    = 2'd1;
          lat_we_nx  = we1;
          lat_add_nx = add1;
          lat_wd_nx  = wd1;
          last_nx    = 1'b0;
        end else if (req2) begin
          grant      = 1'b1;
          port_nx    = 2'd2;
          lat_we_nx  = we2;
          lat_add_nx = add2;
          lat_wd_nx  = wd2;
          last_nx    = 1'b1;
        end
        if (grant) state_nx = SETUP;
      end
      SETUP: begin
        state_nx = ACCESS;
        cnt_nx   = ACC_LAST;
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nx = HOLD;
        else             cnt_nx   = cnt - 4'd1;
      end
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      port    <= 2'd0;
      lat_we  <= 1'b0;
      lat_add <= '0;
      lat_wd  <= 8'h00;
      cnt     <= 4'd0;
      last    <= 1'b1;
    end else begin
      state   <= state_nx;
      port    <= port_nx;
      lat_we  <= lat_we_nx;
      lat_add <= lat_add_nx;
      lat_wd  <= lat_wd_nx;
      cnt     <= cnt_nx;
      last    <= last_nx;
    end
  end

  // Pin outputs are decoded from the next state so every SRAM strobe comes straight off a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_cs_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_doe  <= 1'b0;
      sram_add  <= '0;
      sram_dout <= 8'h00;
      rdata     <= 8'h00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      ack2      <= 1'b0;
    end else begin
      sram_cs_n <= (state_nx == IDLE);
      sram_oe_n <= !((state_nx == ACCESS) && !lat_we_nx);
      sram_we_n <= !((state_nx == ACCESS) && lat_we_nx);
      sram_doe  <= (state_nx != IDLE) && lat_we_nx;
      sram_add  <= lat_add_nx;
      if (grant && lat_we_nx) sram_dout <= lat_wd_nx;
      if ((state == ACCESS) && (cnt == 4'd0) && !lat_we) rdata <= sram_din;
      ack0 <= (state_nx == HOLD) && (port_nx == 2'd0);
      ack1 <= (state_nx == HOLD) && (port_nx == 2'd1);
      ack2 <= (state_nx == HOLD) && (port_nx == 2'd2);
    end
  end

  assign busy = (state != IDLE);

endmodule
